// File: rtl/sdram_tester_pkg.sv
// Shared definitions for the SDRAM pattern tester.
//   state_t    : tester FSM state encoding
//   PAT_*      : pattern mode codes for the 2-bit mode input
//   WDOG_LIMIT : handshake watchdog terminal count, used when
//                SDRAM_TESTER_WATCHDOG_EN is defined
package sdram_tester_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_REQ,
    WR_ACK,
    WR_DONE,
    RD_REQ,
    RD_ACK,
    RD_DONE,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] PAT_INC   = 2'd0;
  localparam logic [1:0] PAT_XOR   = 2'd1;
  localparam logic [1:0] PAT_WALK1 = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test-word generator. The same instance feeds both the write
// data and the read-back compare, so the two paths always agree.
//   mode : pattern select (PAT_*)
//   seed : per-pass seed
//   idx  : test index, zero-extended or truncated to DATA_W
//   word : expected data word
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] idx_d;
  logic [DATA_W:0]   walk_sum;
  logic [DATA_W-1:0] walk_pos;

  always_comb begin
    idx_d    = DATA_W'(idx);
    // One extra bit keeps the sum exact before the modulo.
    walk_sum = {1'b0, idx_d} + {1'b0, seed};
    walk_pos = DATA_W'(32'(walk_sum) % DATA_W);
    case (mode)
      PAT_INC:   word = seed + idx_d;
      PAT_XOR:   word = seed ^ idx_d;
      PAT_WALK1: word = {{(DATA_W-1){1'b0}}, 1'b1} << walk_pos;
      default:   word = idx[0] ? ~seed : seed;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: write sweep over a 2^N word window, then a read-back
// compare sweep, repeated PASSES times (0 = until stop).
// Optional feature macro: SDRAM_TESTER_WATCHDOG_EN adds a 16-bit handshake
// watchdog and the timeout output.
// Ports:
//   CLK_160_COMMON, reset (async, active-low)
//   start/stop/mode/seed       : run control
//   drv_start_write/read, drv_row/col/bank, wr_data, drv_busy, rd_valid,
//   rd_data                    : SDRAM driver handshake
//   busy/done/pass_ok, err_count, pass_count, first_err_* : results
//   timeout                    : watchdog expiry (watchdog build only)
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COL_BITS  = 3,
  parameter int ROW_BITS  = 3,
  parameter int BANK_BITS = 2,
  parameter int PASSES    = 1,
  parameter int ERR_W     = 16
) (
  input  logic                                  CLK_160_COMMON,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [1:0]                            mode,
  input  logic [DATA_W-1:0]                     seed,
  output logic                                  drv_start_write,
  output logic                                  drv_start_read,
  output logic [12:0]                           drv_row,
  output logic [12:0]                           drv_col,
  output logic [1:0]                            drv_bank,
  output logic [DATA_W-1:0]                     wr_data,
  input  logic                                  drv_busy,
  input  logic                                  rd_valid,
  input  logic [DATA_W-1:0]                     rd_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass_ok,
  output logic [ERR_W-1:0]                      err_count,
  output logic [ERR_W-1:0]                      pass_count,
  output logic [COL_BITS+ROW_BITS+BANK_BITS-1:0] first_err_idx,
  output logic [DATA_W-1:0]                     first_err_exp,
`ifdef SDRAM_TESTER_WATCHDOG_EN
  output logic                                  timeout,
`endif
  output logic [DATA_W-1:0]                     first_err_got
);

  localparam int IDX_W = COL_BITS + ROW_BITS + BANK_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t            state, next_state;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] seed_run;
  logic [DATA_W-1:0] exp_word;
  logic              in_read;   // 1 while sweeping the read-back phase
  logic              rd_seen;   // rd_valid already consumed for this word
  logic              armed;     // first-error latch still open
  logic              start_run, idx_step, idx_clear, pass_end;
  logic              rd_sample, rd_miss, wd_fire;
  logic              mismatch, err_hit;
  logic [ERR_W-1:0]  pass_next;

  sdram_pattern_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_gen (
    .mode (mode_r),
    .seed (seed_run),
    .idx  (idx),
    .word (exp_word)
  );

  // Address and data derive from idx, which only moves in NEXT, so they are
  // stable for the whole request/acknowledge/complete sequence.
  assign wr_data = exp_word;
  assign drv_col = 13'(idx[COL_BITS-1:0]);
  assign drv_row = 13'(idx[COL_BITS +: ROW_BITS]);
  generate
    if (BANK_BITS > 0) begin : g_bank
      assign drv_bank = 2'(idx[COL_BITS+ROW_BITS +: BANK_BITS]);
    end else begin : g_no_bank
      assign drv_bank = 2'b00;
    end
  endgenerate

  // Start strobes decode straight from state so an asynchronous reset drops
  // them immediately; one state each makes them mutually exclusive.
  assign drv_start_write = (state == WR_ACK);
  assign drv_start_read  = (state == RD_ACK);
  assign busy            = (state != IDLE) && (state != DONE);
  assign done            = (state == DONE);
  assign pass_ok         = done && (err_count == '0);

  assign pass_next = (pass_count == '1) ? pass_count : pass_count + 1'b1;
  assign mismatch  = rd_sample && (rd_data != exp_word);
  assign err_hit   = mismatch || rd_miss || wd_fire;

`ifdef SDRAM_TESTER_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_active;
  assign wd_active = (state == WR_ACK) || (state == WR_DONE) ||
                     (state == RD_ACK) || (state == RD_DONE);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_160_COMMON or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    start_run  = 1'b0;
    idx_step   = 1'b0;
    idx_clear  = 1'b0;
    pass_end   = 1'b0;
    rd_sample  = 1'b0;
    rd_miss    = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        start_run  = 1'b1;
        next_state = WR_REQ;
      end
      WR_REQ:  if (!drv_busy) next_state = WR_ACK;
      WR_ACK:  if (drv_busy)  next_state = WR_DONE;
      WR_DONE: if (!drv_busy) next_state = NEXT;
      RD_REQ:  if (!drv_busy) next_state = RD_ACK;
      RD_ACK:  if (drv_busy)  next_state = RD_DONE;
      RD_DONE: begin
        rd_sample = rd_valid && !rd_seen;
        if (!drv_busy) begin
          next_state = NEXT;
          rd_miss    = !rd_seen && !rd_valid;
        end
      end
      NEXT: begin
        if (stop) begin
          next_state = DONE;
        end else if (idx != IDX_LAST) begin
          idx_step   = 1'b1;
          next_state = in_read ? RD_REQ : WR_REQ;
        end else if (!in_read) begin
          idx_clear  = 1'b1;
          next_state = RD_REQ;
        end else begin
          pass_end = 1'b1;
          if (PASSES != 0 && 32'(pass_next) == 32'(PASSES)) begin
            next_state = DONE;
          end else begin
            idx_clear  = 1'b1;
            next_state = WR_REQ;
          end
        end
      end
      default: next_state = IDLE;
    endcase
`ifdef SDRAM_TESTER_WATCHDOG_EN
    if (wd_active && wd_cnt == WDOG_LIMIT) begin
      wd_fire    = 1'b1;
      rd_sample  = 1'b0;
      rd_miss    = 1'b0;
      next_state = DONE;
    end
`endif
  end

  always_ff @(posedge CLK_160_COMMON or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      mode_r        <= '0;
      seed_run      <= '0;
      in_read       <= 1'b0;
      rd_seen       <= 1'b0;
      armed         <= 1'b1;
      err_count     <= '0;
      pass_count    <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start_run) begin
      idx           <= '0;
      mode_r        <= mode;
      seed_run      <= seed;
      in_read       <= 1'b0;
      rd_seen       <= 1'b0;
      armed         <= 1'b1;
      err_count     <= '0;
      pass_count    <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      if (state == RD_REQ) rd_seen <= 1'b0;
      else if (rd_sample)  rd_seen <= 1'b1;
      if (err_hit && err_count != '1) err_count <= err_count + 1'b1;
      if ((mismatch || rd_miss) && armed) begin
        armed         <= 1'b0;
        first_err_idx <= idx;
        first_err_exp <= exp_word;
        first_err_got <= mismatch ? rd_data : '0;
      end
      if (idx_step)       idx <= idx + 1'b1;
      else if (idx_clear) idx <= '0;
      if (pass_end) begin
        pass_count <= pass_next;
        seed_run   <= seed_run + 1'b1;
      end
      if (next_state == RD_REQ)      in_read <= 1'b1;
      else if (next_state == WR_REQ) in_read <= 1'b0;
    end
  end

`ifdef SDRAM_TESTER_WATCHDOG_EN
  always_ff @(posedge CLK_160_COMMON or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_active ? wd_cnt + 1'b1 : '0;
      if (start_run)    timeout <= 1'b0;
      else if (wd_fire) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester (default parameters). A behavioural SDRAM
// driver answers requests from a small memory; expected write/read requests
// are queued per run and popped as the driver accepts each request.
`timescale 1ns/1ps
module tb_sdram_pattern_tester;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } item_t;

  logic        clk;
  logic        reset, start, stop;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic        drv_start_write, drv_start_read;
  logic [12:0] drv_row, drv_col;
  logic [1:0]  drv_bank;
  logic [15:0] wr_data;
  logic        drv_busy, rd_valid;
  logic [15:0] rd_data;
  logic        busy, done, pass_ok;
  logic [15:0] err_count, pass_count;
  logic [7:0]  first_err_idx;
  logic [15:0] first_err_exp, first_err_got;
`ifdef SDRAM_TESTER_WATCHDOG_EN
  logic        timeout;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  item_t       wr_q[$];
  int          rd_q[$];
  logic [15:0] mem[0:255];
  logic        model_clear, stuck_busy;
  int          corrupt_idx, noresp_a, noresp_b, last_rd_idx;
  logic [15:0] corrupt_mask;

  sdram_pattern_tester dut (
    .CLK_160_COMMON  (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .mode            (mode),
    .seed            (seed),
    .drv_start_write (drv_start_write),
    .drv_start_read  (drv_start_read),
    .drv_row         (drv_row),
    .drv_col         (drv_col),
    .drv_bank        (drv_bank),
    .wr_data         (wr_data),
    .drv_busy        (drv_busy),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done),
    .pass_ok         (pass_ok),
    .err_count       (err_count),
    .pass_count      (pass_count),
    .first_err_idx   (first_err_idx),
    .first_err_exp   (first_err_exp),
`ifdef SDRAM_TESTER_WATCHDOG_EN
    .timeout         (timeout),
`endif
    .first_err_got   (first_err_got)
  );

  initial begin
    clk = 1'b0;
    forever #3 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [1:0] m, input logic [15:0] s, input int i);
    case (m)
      2'd0:    return s + 16'(i);
      2'd1:    return s ^ 16'(i);
      2'd2:    return 16'h1 << ((i + int'(s)) % 16);
      default: return i[0] ? ~s : s;
    endcase
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {4'h0, b[7:6], 13'(b[5:3]), 13'(b[2:0])};
  endfunction

  // Driver model: request taken at a falling edge, busy for 4 cycles,
  // read data valid for one cycle at the end of the busy window.
  initial begin : drv_model
    int    cnt;
    logic  op_rd;
    int    a_idx;
    item_t it;
    int    e_rd;
    drv_busy = 1'b0; rd_valid = 1'b0; rd_data = '0;
    cnt = 0; op_rd = 1'b0; a_idx = 0;
    forever begin
      @(negedge clk);
      if (model_clear) begin
        drv_busy = 1'b0; rd_valid = 1'b0; rd_data = '0; cnt = 0;
      end else if (!drv_busy) begin
        if (drv_start_write || drv_start_read) begin
          a_idx    = int'({drv_bank, drv_row[2:0], drv_col[2:0]});
          op_rd    = drv_start_read;
          drv_busy = 1'b1;
          cnt      = 4;
          if (drv_start_write) begin
            check("wr_rd_exclusive", drv_start_read, 0);
            check("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
              it = wr_q.pop_front();
              check("wr_addr", {4'h0, drv_bank, drv_row, drv_col}, addr_of(it.idx));
              check("wr_data", wr_data, it.data);
            end
            mem[a_idx] = wr_data;
          end else begin
            check("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
              e_rd = rd_q.pop_front();
              check("rd_addr", {4'h0, drv_bank, drv_row, drv_col}, addr_of(e_rd));
            end
            last_rd_idx = a_idx;
          end
        end
      end else if (!stuck_busy) begin
        cnt--;
        if (cnt == 1 && op_rd && a_idx != noresp_a && a_idx != noresp_b) begin
          rd_valid = 1'b1;
          rd_data  = mem[a_idx] ^ ((a_idx == corrupt_idx) ? corrupt_mask : 16'h0000);
        end
        if (cnt == 0) begin
          drv_busy = 1'b0;
          rd_valid = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [1:0] m, input logic [15:0] s);
    wr_q.delete();
    rd_q.delete();
    last_rd_idx = -1;
    for (int i = 0; i < 256; i++) begin
      wr_q.push_back('{idx: i, data: pat(m, s, i)});
      rd_q.push_back(i);
    end
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_result(input string tag, input logic ok, input int errs, input int passes);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_pass_ok"}, pass_ok, ok);
    check({tag, "_errs"},    err_count, errs);
    check({tag, "_passes"},  pass_count, passes);
  endtask

  initial begin : main
    int k;
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; seed = '0;
    model_clear = 1'b1; stuck_busy = 1'b0;
    corrupt_idx = -1; corrupt_mask = '0; noresp_a = -1; noresp_b = -1; last_rd_idx = -1;
    repeat (3) @(negedge clk);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_pass_ok",   pass_ok, 0);
    check("rst_start_wr",  drv_start_write, 0);
    check("rst_start_rd",  drv_start_read, 0);
    check("rst_addr",      {4'h0, drv_bank, drv_row, drv_col}, 0);
    check("rst_wr_data",   wr_data, 0);
    check("rst_err_count", err_count, 0);
    check("rst_pass_cnt",  pass_count, 0);
    check("rst_ferr_idx",  first_err_idx, 0);
    check("rst_ferr_exp",  first_err_exp, 0);
    check("rst_ferr_got",  first_err_got, 0);
    reset = 1'b1; model_clear = 1'b0;
    @(negedge clk);

    // Clean incrementing run.
    run(2'd0, 16'h0000);
    wait_done(10000, "inc_done");
    check_result("inc", 1'b1, 0, 1);
    check("inc_wr_left", wr_q.size(), 0);
    check("inc_rd_left", rd_q.size(), 0);
`ifdef SDRAM_TESTER_WATCHDOG_EN
    check("inc_timeout", timeout, 0);
`endif

    // Corrupted read at idx 37; a start pulse mid-run must be ignored.
    corrupt_idx = 37; corrupt_mask = 16'h0004;
    run(2'd0, 16'h1000);
    repeat (20) @(negedge clk);
    mode = 2'd2; seed = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10000, "cor_done");
    check_result("cor", 1'b0, 1, 1);
    check("cor_ferr_idx", first_err_idx, 37);
    check("cor_ferr_exp", first_err_exp, 16'h1025);
    check("cor_ferr_got", first_err_got, 16'h1021);
    check("cor_rd_left",  rd_q.size(), 0);
    corrupt_idx = -1;

    // Stop while reading idx 100: that word completes, then DONE.
    run(2'd3, 16'h5A5A);
    k = 0;
    while (last_rd_idx != 100 && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("stop_reach_rd100", last_rd_idx, 100);
    stop = 1'b1;
    wait_done(200, "stop_done");
    stop = 1'b0;
    check_result("stop", 1'b1, 0, 0);
    check("stop_last_rd", last_rd_idx, 100);
    check("stop_rd_left", rd_q.size(), 155);

    // Missing read data at idx 5 and 9.
    noresp_a = 5; noresp_b = 9;
    run(2'd1, 16'h00F0);
    wait_done(10000, "nrsp_done");
    check_result("nrsp", 1'b0, 2, 1);
    check("nrsp_ferr_idx", first_err_idx, 5);
    check("nrsp_ferr_exp", first_err_exp, 16'h00F5);
    check("nrsp_ferr_got", first_err_got, 0);
    noresp_a = -1; noresp_b = -1;

    // Reset asserted while a write request is being held.
    run(2'd2, 16'h0003);
    k = 0;
    while (!drv_start_write && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("arst_in_wr_ack", drv_start_write, 1);
    reset = 1'b0; model_clear = 1'b1;
    #1;
    check("arst_start_wr", drv_start_write, 0);
    check("arst_busy",     busy, 0);
    check("arst_done",     done, 0);
    check("arst_errs",     err_count, 0);
    check("arst_ferr_exp", first_err_exp, 0);
    check("arst_addr",     {4'h0, drv_bank, drv_row, drv_col}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; model_clear = 1'b0;
    @(negedge clk);
    run(2'd2, 16'h0003);
    wait_done(10000, "walk_done");
    check_result("walk", 1'b1, 0, 1);
    check("walk_wr_left", wr_q.size(), 0);

`ifdef SDRAM_TESTER_WATCHDOG_EN
    // Driver hangs busy after the first write.
    stuck_busy = 1'b1;
    run(2'd0, 16'h0000);
    wait_done(70000, "wdog_done");
    check("wdog_timeout", timeout, 1);
    check("wdog_errs", err_count, 1);
    check("wdog_busy", busy, 0);
    stuck_busy = 1'b0; model_clear = 1'b1;
    repeat (2) @(negedge clk);
    model_clear = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
